// File: rtl/rv32i_prog_loader.sv
// Run-time program loader for rv32i_core: takes a length-prefixed little-endian byte stream,
// writes it into instruction memory, then releases the core and waits for it to halt.
module rv32i_prog_loader #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned IMEM_AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst_n,
  input  logic               core_halted,
  output logic               done,
  output logic               err,
  output logic [15:0]        word_count
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    FLUSH,
    RUN,
    DONE,
    ERR
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [15:0]        len;
  logic [15:0]        len_full;
  logic [1:0]         byte_idx;
  logic [IMEM_AW-1:0] word_idx;
  logic [23:0]        asm_lo;
  logic               run_first;
  logic               xfer;
  logic               last_word;

  assign xfer      = in_valid & in_ready;
  assign len_full  = {in_data, len[7:0]};
  assign last_word = (32'(word_idx) + 32'd1) == 32'(len);

  always_ff @(posedge clk) begin
    if (rst) state <= LEN_LO;
    else     state <= state_next;
  end

  // Outputs decode only the state register, so none of them follows in_valid or core_halted
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    core_rst_n = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_full == 16'd0)                  state_next = RUN;
          else if (32'(len_full) > IMEM_WORDS)    state_next = ERR;
          else                                    state_next = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && byte_idx == 2'd3 && last_word) state_next = FLUSH;
      end
      FLUSH: state_next = RUN;
      RUN: begin
        core_rst_n = 1'b1;
        if (core_halted && !run_first) state_next = DONE;
      end
      DONE: begin
        core_rst_n = 1'b1;
        done       = 1'b1;
      end
      ERR:     err = 1'b1;
      default: state_next = LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len        <= '0;
      byte_idx   <= '0;
      word_idx   <= '0;
      asm_lo     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      run_first  <= 1'b1;
    end else begin
      imem_we   <= 1'b0;
      // High only during the first RUN cycle, while the core is still leaving reset
      run_first <= (state != RUN);
      if (imem_we) word_count <= word_count + 16'd1;
      case (state)
        LEN_LO: if (xfer) len[7:0] <= in_data;
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= in_data;
            byte_idx  <= '0;
            word_idx  <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_lo[7:0]   <= in_data;
              2'd1: asm_lo[15:8]  <= in_data;
              2'd2: asm_lo[23:16] <= in_data;
              2'd3: begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx;
                imem_wdata <= {in_data, asm_lo};
                if (!last_word) word_idx <= word_idx + IMEM_AW'(1);
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_prog_loader.sv
// Randomized scoreboard bench for rv32i_prog_loader; core_halted is driven by the bench.
module tb_rv32i_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        core_halted = 1'b0;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  rv32i_prog_loader #(.IMEM_WORDS(256), .IMEM_AW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .core_halted(core_halted),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          mon_en   = 1'b0;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img[256];
  int unsigned acc_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Every imem write must match the oldest word the stimulus completed, in the cycle after its 4th byte
  always @(negedge clk) begin
    if (mon_en && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("imem_we_without_pending_word", {31'd0, imem_we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {24'd0, imem_addr}, mon_e.addr);
        chk("wr_data", imem_wdata, mon_e.data);
        chk("wr_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at posedge+1; returns at posedge+1 just after the edge that accepted the byte
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned budget;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    budget   = 50;
    while (in_ready !== 1'b1 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      chk("send_timeout_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] len, input bit gaps);
    send_byte(len[7:0], gaps);
    send_byte(len[15:8], gaps);
  endtask

  task automatic load_words(input int unsigned n, input bit gaps);
    logic [31:0] w;
    for (int unsigned i = 0; i < n; i++) begin
      w = img[i];
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gaps);
      exp_q.push_back('{addr: i, data: w, cyc: acc_cyc});
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    core_halted = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mon_en   = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Entered right after the last accepted byte; halted held through the ignored first RUN cycle
  task automatic finish_and_run(input int unsigned n);
    @(negedge clk);
    chk("rst_n_low_during_final_write", {31'd0, core_rst_n}, 32'd0);
    @(posedge clk);
    #1;
    core_halted = 1'b1;
    @(negedge clk);
    chk("rst_n_release", {31'd0, core_rst_n}, 32'd1);
    chk("word_count_final", {16'd0, word_count}, n);
    chk("done_not_in_first_run", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_first_halt_ignored", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    core_halted = 1'b0;
    @(negedge clk);
    chk("done_after_held_halt", {31'd0, done}, 32'd1);
  endtask

  logic [15:0] bad_len;

  initial begin
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    do_reset();

    // 6 words back to back; halt pulse only in the first RUN cycle must be ignored
    send_len(16'd6, 1'b0);
    load_words(6, 1'b0);
    @(negedge clk);
    chk("p1_rst_n_low_during_final_write", {31'd0, core_rst_n}, 32'd0);
    @(posedge clk);
    #1;
    core_halted = 1'b1;
    @(negedge clk);
    chk("p1_rst_n_release", {31'd0, core_rst_n}, 32'd1);
    chk("p1_word_count", {16'd0, word_count}, 32'd6);
    @(posedge clk);
    #1;
    core_halted = 1'b0;
    in_valid    = 1'b1;
    in_data     = 8'($urandom);
    repeat (3) begin
      @(negedge clk);
      chk("p1_done_still_low", {31'd0, done}, 32'd0);
      chk("p1_in_ready_run", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    core_halted = 1'b1;
    @(posedge clk);
    #1;
    core_halted = 1'b0;
    @(negedge clk);
    chk("p1_done", {31'd0, done}, 32'd1);
    chk("p1_done_rst_n", {31'd0, core_rst_n}, 32'd1);
    repeat (4) @(negedge clk);
    chk("p1_done_sticky", {31'd0, done}, 32'd1);
    chk("p1_word_count_hold", {16'd0, word_count}, 32'd6);

    // Same image with random gaps between bytes
    do_reset();
    send_len(16'd6, 1'b1);
    load_words(6, 1'b1);
    finish_and_run(6);

    // Over-length headers
    for (int t = 0; t < 2; t++) begin
      bad_len = (t == 0) ? 16'd257 : 16'($urandom_range(258, 65535));
      do_reset();
      send_len(bad_len, 1'b0);
      @(negedge clk);
      chk("err_set", {31'd0, err}, 32'd1);
      chk("err_in_ready", {31'd0, in_ready}, 32'd0);
      chk("err_core_rst_n", {31'd0, core_rst_n}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      repeat (4) begin
        @(negedge clk);
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("err_no_accept", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("err_word_count", {16'd0, word_count}, 32'd0);
    end

    // Zero-length image
    do_reset();
    send_len(16'd0, 1'b0);
    @(negedge clk);
    chk("zero_rst_n_release", {31'd0, core_rst_n}, 32'd1);
    chk("zero_word_count", {16'd0, word_count}, 32'd0);
    chk("zero_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("zero_done_low", {31'd0, done}, 32'd0);

    // Full-depth image, also exercised as reset-while-running by the next do_reset
    do_reset();
    send_len(16'd256, 1'b0);
    load_words(256, 1'b0);
    finish_and_run(256);

    // Abort after 2.5 words
    do_reset();
    send_len(16'd6, 1'b0);
    load_words(2, 1'b0);
    send_byte(img[2][7:0], 1'b0);
    send_byte(img[2][15:8], 1'b0);
    do_reset();

    // Abort with rst coinciding with the word's 4th byte: that word must never be written
    send_len(16'd6, 1'b0);
    load_words(2, 1'b1);
    send_byte(img[2][7:0], 1'b0);
    send_byte(img[2][15:8], 1'b0);
    send_byte(img[2][23:16], 1'b0);
    in_valid = 1'b1;
    in_data  = img[2][31:24];
    do_reset();

    // Fresh image after the aborts
    for (int i = 0; i < 8; i++) img[i] = $urandom;
    begin
      int unsigned n;
      n = $urandom_range(1, 8);
      send_len(16'(n), 1'b1);
      load_words(n, 1'b1);
      finish_and_run(n);
    end
    repeat (2) @(negedge clk);
    chk("final_scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
